// File: rtl/ysyx_23060042_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB,
// with bus-timeout detection, ebreak halt and a retired-instruction counter.
module ysyx_23060042_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ifu_ack,
    input  logic             lsu_ack,
    input  logic             idu_regen,
    input  logic             idu_pcjen,
    input  logic             idu_mwen,
    input  logic             idu_brken,
    input  logic             idu_is_load,
    output logic             ifu_req,
    output logic             inst_latch,
    output logic             lsu_req,
    output logic             lsu_wen,
    output logic             reg_wen,
    output logic             pc_wen,
    output logic             pc_sel_jump,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    // A zero TIMEOUT still needs a 1-bit counter so the logic stays legal.
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic              f_regen;
    logic              f_pcjen;
    logic              f_mwen;
    logic              f_is_load;
    logic              timed_out;
    logic              retire;
    logic              waiting;

    assign timed_out = (TIMEOUT > 0) && (wait_q == WAIT_LAST);
    assign retire    = (state_q == WB) || (state_q == DECODE && idu_brken);
    assign waiting   = (state_q == FETCH && !ifu_ack) || (state_q == MEM && !lsu_ack);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH: begin
                if (ifu_ack)        state_d = DECODE;
                else if (timed_out) state_d = ERR;
            end
            DECODE: state_d = idu_brken ? HALT : EXEC;
            EXEC:   state_d = (f_mwen || f_is_load) ? MEM : WB;
            MEM: begin
                if (lsu_ack)        state_d = WB;
                else if (timed_out) state_d = ERR;
            end
            WB:     state_d = FETCH;
            HALT:   state_d = HALT;
            ERR:    state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            f_regen   <= 1'b0;
            f_pcjen   <= 1'b0;
            f_mwen    <= 1'b0;
            f_is_load <= 1'b0;
            instret   <= '0;
        end else begin
            state_q <= state_d;
            // Counter is idle-zero outside a wait, so every entry to FETCH/MEM starts at 0.
            if (waiting) wait_q <= wait_q + 1'b1;
            else         wait_q <= '0;
            if (state_q == DECODE) begin
                f_regen   <= idu_regen;
                f_pcjen   <= idu_pcjen;
                f_mwen    <= idu_mwen;
                f_is_load <= idu_is_load;
            end
            if (retire) instret <= instret + 1'b1;
        end
    end

    assign state       = state_q;
    assign ifu_req     = (state_q == FETCH);
    assign inst_latch  = (state_q == FETCH) && ifu_ack;
    assign lsu_req     = (state_q == MEM);
    assign lsu_wen     = (state_q == MEM) && f_mwen;
    assign pc_wen      = (state_q == WB);
    assign pc_sel_jump = (state_q == WB) && f_pcjen;
    assign reg_wen     = (state_q == WB) && f_regen && !f_mwen;
    assign halted      = (state_q == HALT) || (state_q == ERR);
    assign bus_err     = (state_q == ERR);

endmodule

// File: tb/tb_ysyx_23060042_seq_ctrl.sv
// Bench for the sequencer: per-cycle expected state/output vectors are queued as
// stimulus is applied and compared against the DUT at the following negedge.
module tb_ysyx_23060042_seq_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;
    localparam logic [8:0] NONE = 9'h000, IFU = 9'h100, LAT = 9'h080, LREQ = 9'h040,
                           LWEN = 9'h020, RWEN = 9'h010, PCW = 9'h008, JMP = 9'h004,
                           HLT = 9'h002, BERR = 9'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ifu_ack = 1'b0;
    logic        lsu_ack = 1'b0;
    logic        idu_regen = 1'b0;
    logic        idu_pcjen = 1'b0;
    logic        idu_mwen = 1'b0;
    logic        idu_brken = 1'b0;
    logic        idu_is_load = 1'b0;
    logic        ifu_req, inst_latch, lsu_req, lsu_wen, reg_wen, pc_wen, pc_sel_jump;
    logic        halted, bus_err;
    logic [2:0]  state;
    logic [31:0] instret;

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    ysyx_23060042_seq_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .ifu_ack(ifu_ack), .lsu_ack(lsu_ack),
        .idu_regen(idu_regen), .idu_pcjen(idu_pcjen), .idu_mwen(idu_mwen),
        .idu_brken(idu_brken), .idu_is_load(idu_is_load),
        .ifu_req(ifu_req), .inst_latch(inst_latch), .lsu_req(lsu_req), .lsu_wen(lsu_wen),
        .reg_wen(reg_wen), .pc_wen(pc_wen), .pc_sel_jump(pc_sel_jump),
        .halted(halted), .bus_err(bus_err), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One clock cycle: queue what this cycle must show, compare at negedge, advance.
    task automatic tick(input string tag, input logic [2:0] st, input logic [8:0] outs);
        logic [11:0] got;
        exp_q.push_back({st, outs});
        @(negedge clk);
        got = {state, ifu_req, inst_latch, lsu_req, lsu_wen, reg_wen, pc_wen,
               pc_sel_jump, halted, bus_err};
        check(tag, 32'(got), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic rg, input logic pj, input logic mw,
                           input logic ld, input logic bk);
        idu_regen = rg; idu_pcjen = pj; idu_mwen = mw; idu_is_load = ld; idu_brken = bk;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        tick("reset_idle", S_IDLE, NONE);
        check("reset_instret", instret, 32'd0);
    endtask

    task automatic kick();
        start = 1'b1;
        tick("idle_start", S_IDLE, NONE);
        start = 1'b0;
    endtask

    initial begin
        // ALU instruction with zero-wait fetch, then a second FETCH in cycle 5
        do_reset();
        ifu_ack = 1'b1; lsu_ack = 1'b0;
        set_dec(1, 0, 0, 0, 0);
        kick();
        tick("alu_fetch", S_FETCH, IFU | LAT);
        tick("alu_decode", S_DEC, NONE);
        tick("alu_exec", S_EXEC, NONE);
        tick("alu_wb", S_WB, RWEN | PCW);
        check("alu_instret", instret, 32'd1);
        ifu_ack = 1'b0;
        tick("alu_fetch2", S_FETCH, IFU);

        // Store with ack on the 4th MEM cycle; idu_mwen flips after DECODE
        do_reset();
        ifu_ack = 1'b1;
        set_dec(0, 0, 1, 0, 0);
        kick();
        tick("st_fetch", S_FETCH, IFU | LAT);
        tick("st_decode", S_DEC, NONE);
        idu_mwen = 1'b0;
        tick("st_exec", S_EXEC, NONE);
        for (int i = 0; i < 4; i++) begin
            lsu_ack = (i == 3);
            idu_mwen = i[0];
            tick("st_mem", S_MEM, LREQ | LWEN);
        end
        lsu_ack = 1'b0;
        tick("st_wb", S_WB, PCW);
        check("st_instret", instret, 32'd1);

        // Load (immediate ack) followed directly by JAL without reset
        set_dec(1, 0, 0, 1, 0);
        lsu_ack = 1'b1;
        tick("ld_fetch", S_FETCH, IFU | LAT);
        tick("ld_decode", S_DEC, NONE);
        tick("ld_exec", S_EXEC, NONE);
        tick("ld_mem", S_MEM, LREQ);
        tick("ld_wb", S_WB, RWEN | PCW);
        check("ld_instret", instret, 32'd2);
        set_dec(1, 1, 0, 0, 0);
        tick("jal_fetch", S_FETCH, IFU | LAT);
        tick("jal_decode", S_DEC, NONE);
        tick("jal_exec", S_EXEC, NONE);
        tick("jal_wb", S_WB, RWEN | PCW | JMP);
        check("jal_instret", instret, 32'd3);

        // ebreak: halt after DECODE, sticky, start ignored
        do_reset();
        lsu_ack = 1'b0;
        set_dec(0, 0, 0, 0, 1);
        kick();
        tick("brk_fetch", S_FETCH, IFU | LAT);
        tick("brk_decode", S_DEC, NONE);
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom_range(0, 1));
            ifu_ack = 1'($urandom_range(0, 1));
            tick("brk_halt", S_HALT, HLT);
        end
        start = 1'b0;
        check("brk_instret", instret, 32'd1);

        // Fetch timeout: 16 FETCH cycles without ack, then ERR, cleared by reset
        do_reset();
        set_dec(0, 0, 0, 0, 0);
        ifu_ack = 1'b0;
        kick();
        for (int i = 0; i < 16; i++) tick("to_fetch", S_FETCH, IFU);
        for (int i = 0; i < 3; i++) tick("to_err", S_ERR, HLT | BERR);
        check("to_instret", instret, 32'd0);
        do_reset();

        // MEM timeout: load whose ack never arrives
        ifu_ack = 1'b1;
        set_dec(1, 0, 0, 1, 0);
        kick();
        tick("mto_fetch", S_FETCH, IFU | LAT);
        tick("mto_decode", S_DEC, NONE);
        tick("mto_exec", S_EXEC, NONE);
        for (int i = 0; i < 16; i++) tick("mto_mem", S_MEM, LREQ);
        tick("mto_err", S_ERR, HLT | BERR);

        // Reset asserted mid-MEM: request drops on the next cycle
        do_reset();
        set_dec(0, 0, 1, 0, 0);
        kick();
        tick("rm_fetch", S_FETCH, IFU | LAT);
        tick("rm_decode", S_DEC, NONE);
        tick("rm_exec", S_EXEC, NONE);
        tick("rm_mem", S_MEM, LREQ | LWEN);
        rst = 1'b1;
        tick("rm_mem_rst", S_MEM, LREQ | LWEN);
        rst = 1'b0;
        tick("rm_idle", S_IDLE, NONE);
        check("rm_instret", instret, 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
